// File: rtl/if_pkg.sv
// Shared encodings for the integrate-and-fire neuron array.
package if_pkg;

  localparam logic [1:0] CFG_THRESH = 2'd0;
  localparam logic [1:0] CFG_REFRAC = 2'd1;
  localparam logic [1:0] CFG_CLR    = 2'd2;

  localparam int unsigned RESET_SUBTRACT = 0;
  localparam int unsigned RESET_ZERO     = 1;

  localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/if_neuron_core.sv
// One integrate-and-fire channel: membrane state, refractory counter,
// leak plus saturating integration, fire decision and spike register.
module if_neuron_core
  import if_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RESET_MODE = 0,
  parameter int unsigned LEAK_SHIFT = 0,
  parameter int unsigned REFRAC_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    current,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [REFRAC_W-1:0] refrac_period,
  output logic                spike,
  output logic [WIDTH-1:0]    state,
  output logic                fire_c
);

  logic [REFRAC_W-1:0] refrac_q;
  logic [WIDTH-1:0]    leak_c;
  logic [WIDTH-1:0]    nxt_c;
  logic [WIDTH:0]      sum_c;

  // Leak never exceeds the state, so the subtraction cannot wrap.
  always_comb begin
    leak_c = (LEAK_SHIFT == 0) ? '0 : (state >> LEAK_SHIFT);
    sum_c  = {1'b0, state - leak_c} + {1'b0, current};
    nxt_c  = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
    fire_c = en && (refrac_q == '0) && (nxt_c >= threshold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= '0;
      refrac_q <= '0;
      spike    <= 1'b0;
    end else begin
      spike <= fire_c;
      if (en) begin
        if (refrac_q != '0) begin
          refrac_q <= refrac_q - REFRAC_W'(1);
        end else if (fire_c) begin
          state    <= (RESET_MODE == RESET_ZERO) ? '0 : (nxt_c - threshold);
          refrac_q <= refrac_period;
        end else begin
          state <= nxt_c;
        end
      end
    end
  end

endmodule

// File: rtl/if_neuron_array.sv
// Array of integrate-and-fire channels sharing threshold/refractory config,
// with a global saturating spike counter.
module if_neuron_array
  import if_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned RESET_MODE     = 0,
  parameter int unsigned LEAK_SHIFT     = 0,
  parameter int unsigned REFRAC_W       = 3,
  parameter int unsigned THRESH_DEFAULT = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] current,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [WIDTH-1:0]          cfg_data,
  output logic [CHANNELS-1:0]       spike,
  output logic [CHANNELS*WIDTH-1:0] state,
  output logic [COUNT_W-1:0]        spike_count
);

  localparam int unsigned POP_W = $clog2(CHANNELS + 1);

  logic [WIDTH-1:0]    threshold_q;
  logic [REFRAC_W-1:0] refrac_q;
  logic [CHANNELS-1:0] fire_c;
  logic [POP_W-1:0]    pop_c;
  logic [COUNT_W-1:0]  base_c;
  logic [COUNT_W:0]    sum_c;
  logic                clr_c;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    if_neuron_core #(
      .WIDTH      (WIDTH),
      .RESET_MODE (RESET_MODE),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC_W   (REFRAC_W)
    ) u_core (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .current       (current[i*WIDTH +: WIDTH]),
      .threshold     (threshold_q),
      .refrac_period (refrac_q),
      .spike         (spike[i]),
      .state         (state[i*WIDTH +: WIDTH]),
      .fire_c        (fire_c[i])
    );
  end

  // A clear in the same cycle as en restarts the count from this step's fires.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop_c = pop_c + POP_W'(fire_c[i]);
    end
    clr_c  = cfg_we && (cfg_sel == CFG_CLR);
    base_c = clr_c ? '0 : spike_count;
    sum_c  = {1'b0, base_c} + (COUNT_W + 1)'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold_q <= WIDTH'(THRESH_DEFAULT);
      refrac_q    <= '0;
      spike_count <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_sel)
          CFG_THRESH: threshold_q <= cfg_data;
          CFG_REFRAC: refrac_q    <= REFRAC_W'(cfg_data);
          default:    ;
        endcase
      end
      spike_count <= sum_c[COUNT_W] ? '1 : sum_c[COUNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_if_neuron_array.sv
// Directed-vector bench for if_neuron_array: subtract, zero-reset and leaky variants.
module tb_if_neuron_array;
  import if_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [N*W-1:0] current = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_sel = 2'd0;
  logic [W-1:0]   cfg_data = '0;

  logic [N-1:0]   spike_a, spike_b, spike_c;
  logic [N*W-1:0] state_a, state_b, state_c;
  logic [15:0]    cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_neuron_array #(.WIDTH(W), .CHANNELS(N), .RESET_MODE(0), .LEAK_SHIFT(0)) u_sub (
    .clk(clk), .rst(rst), .en(en), .current(current), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .spike(spike_a), .state(state_a), .spike_count(cnt_a));

  if_neuron_array #(.WIDTH(W), .CHANNELS(N), .RESET_MODE(1), .LEAK_SHIFT(0)) u_zero (
    .clk(clk), .rst(rst), .en(en), .current(current), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .spike(spike_b), .state(state_b), .spike_count(cnt_b));

  if_neuron_array #(.WIDTH(W), .CHANNELS(N), .RESET_MODE(0), .LEAK_SHIFT(2)) u_leak (
    .clk(clk), .rst(rst), .en(en), .current(current), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .spike(spike_c), .state(state_c), .spike_count(cnt_c));

  typedef struct {
    logic        r;
    logic        e;
    logic [31:0] cur;
    logic        we;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  exp_spike;
    logic [31:0] exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t v(logic r, logic e, logic [31:0] cur, logic we, logic [1:0] sel,
                             logic [7:0] data, logic [3:0] xs, logic [31:0] xst, logic [15:0] xc);
    vec_t t;
    t.r = r; t.e = e; t.cur = cur; t.we = we; t.sel = sel; t.data = data;
    t.exp_spike = xs; t.exp_state = xst; t.exp_cnt = xc;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(logic r, logic e, logic [31:0] cur, logic we, logic [1:0] sel, logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; current = cur; cfg_we = we; cfg_sel = sel; cfg_data = d;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[24];

  initial begin
    tbl[0]  = v(1, 0, 32'h0,        0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd0);
    tbl[1]  = v(0, 1, 32'd60,       0, 2'd0, 8'd0,  4'h0, 32'd60,       16'd0);
    tbl[2]  = v(0, 1, 32'd60,       0, 2'd0, 8'd0,  4'h0, 32'd120,      16'd0);
    tbl[3]  = v(0, 1, 32'd60,       0, 2'd0, 8'd0,  4'h0, 32'd180,      16'd0);
    tbl[4]  = v(0, 1, 32'd60,       0, 2'd0, 8'd0,  4'h1, 32'd40,       16'd1);
    tbl[5]  = v(0, 0, 32'd60,       0, 2'd0, 8'd0,  4'h0, 32'd40,       16'd1);
    tbl[6]  = v(0, 1, 32'd20,       1, 2'd0, 8'd50, 4'h0, 32'd60,       16'd1);
    tbl[7]  = v(0, 1, 32'd0,        0, 2'd0, 8'd0,  4'h1, 32'd10,       16'd2);
    tbl[8]  = v(1, 0, 32'h0,        0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd0);
    tbl[9]  = v(0, 0, 32'h0,        1, 2'd1, 8'd2,  4'h0, 32'h0,        16'd0);
    tbl[10] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h1, 32'h0,        16'd1);
    tbl[11] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd1);
    tbl[12] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd1);
    tbl[13] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h1, 32'h0,        16'd2);
    tbl[14] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd2);
    tbl[15] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd2);
    tbl[16] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h1, 32'h0,        16'd3);
    tbl[17] = v(1, 0, 32'h0,        0, 2'd0, 8'd0,  4'h0, 32'h0,        16'd0);
    tbl[18] = v(0, 1, 32'hC8C8C8C8, 0, 2'd0, 8'd0,  4'hF, 32'h0,        16'd4);
    tbl[19] = v(0, 1, 32'hC8C8C8C8, 1, 2'd2, 8'd0,  4'hF, 32'h0,        16'd4);
    tbl[20] = v(0, 1, 32'h64646464, 0, 2'd0, 8'd0,  4'h0, 32'h64646464, 16'd4);
    tbl[21] = v(1, 1, 32'h64646464, 1, 2'd0, 8'd50, 4'h0, 32'h0,        16'd0);
    tbl[22] = v(0, 1, 32'd200,      0, 2'd0, 8'd0,  4'h1, 32'h0,        16'd1);
    tbl[23] = v(0, 0, 32'h0,        1, 2'd2, 8'd0,  4'h0, 32'h0,        16'd0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].cur, tbl[i].we, tbl[i].sel, tbl[i].data);
      chk($sformatf("row%0d_spike", i), 32'(spike_a), 32'(tbl[i].exp_spike));
      chk($sformatf("row%0d_state", i), state_a, tbl[i].exp_state);
      chk($sformatf("row%0d_count", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
    end

    // Zero-reset mode fires on 250 and drops to 0; subtract mode keeps 50.
    drive(1, 0, 32'd0, 0, 2'd0, 8'd0);
    drive(0, 1, 32'd250, 0, 2'd0, 8'd0);
    chk("zero_fire_spike", 32'(spike_b), 32'h1);
    chk("zero_fire_state", state_b, 32'h0);
    chk("sub_fire_state", state_a, 32'd50);

    // Saturation: state 200 plus 255 clamps to 255 before comparing to 201.
    drive(1, 0, 32'd0, 0, 2'd0, 8'd0);
    drive(0, 0, 32'd0, 1, 2'd0, 8'd201);
    drive(0, 1, 32'd200, 0, 2'd0, 8'd0);
    chk("sat_pre_state", state_a, 32'd200);
    chk("sat_pre_spike", 32'(spike_a), 32'h0);
    drive(0, 1, 32'd255, 0, 2'd0, 8'd0);
    chk("sat_sub_spike", 32'(spike_a), 32'h1);
    chk("sat_sub_state", state_a, 32'd54);
    chk("sat_zero_spike", 32'(spike_b), 32'h1);
    chk("sat_zero_state", state_b, 32'h0);

    // Leak of state>>2: 100 -> 75 -> 57 -> 43, then idle cycles hold everything.
    drive(1, 0, 32'd0, 0, 2'd0, 8'd0);
    drive(0, 1, 32'd100, 0, 2'd0, 8'd0);
    chk("leak_load", state_c, 32'd100);
    drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    chk("leak_75", state_c, 32'd75);
    drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    chk("leak_57", state_c, 32'd57);
    drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    chk("leak_43", state_c, 32'd43);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 32'hFFFFFFFF, 0, 2'd0, 8'd0);
      chk($sformatf("idle%0d_leak_state", k), state_c, 32'd43);
      chk($sformatf("idle%0d_leak_spike", k), 32'(spike_c), 32'h0);
      chk($sformatf("idle%0d_sub_state", k), state_a, 32'd100);
    end

    // Threshold 0: every channel fires every step until the count saturates.
    drive(1, 0, 32'd0, 0, 2'd0, 8'd0);
    drive(0, 0, 32'd0, 1, 2'd0, 8'd0);
    for (int k = 0; k < 16383; k++) begin
      drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    end
    chk("thr0_spike", 32'(spike_a), 32'hF);
    chk("thr0_state", state_a, 32'h0);
    chk("cnt_65532", 32'(cnt_a), 32'd65532);
    drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    chk("cnt_sat", 32'(cnt_a), 32'd65535);
    drive(0, 1, 32'd0, 0, 2'd0, 8'd0);
    chk("cnt_sat_hold", 32'(cnt_a), 32'd65535);
    drive(0, 0, 32'd0, 0, 2'd0, 8'd0);
    chk("idle_spike_low", 32'(spike_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
